// File: rtl/id_ex_operand_stage_pkg.sv
// Shared pipeline definitions for the ID/EX operand stage.
package id_ex_operand_stage_pkg;

  // R15 is the program counter and is never forwarded or stalled on
  localparam logic [3:0] REG_PC = 4'd15;

  // Width of the opaque decoded-control bundle handed to EX
  localparam int CTRL_W = 16;

  // Operand source select, youngest writer has the highest code
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_WB  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_EX  = 2'd3
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// ID/EX operand stage bus: ID fields, register file data, downstream writers
// in, EX register outputs and stall out.
interface id_ex_operand_stage_if
  import id_ex_operand_stage_pkg::*;
;
  logic              id_valid;
  logic [3:0]        id_sa, id_sb, id_sd;
  logic              id_use_a, id_use_b, id_use_d;
  logic [3:0]        id_rd;
  logic              id_rf_en, id_load;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       pa, pb, pd;
  logic [31:0]       ex_fwd_result;
  logic [3:0]        mem_rd;
  logic              mem_rf_en, mem_valid;
  logic [31:0]       mem_result;
  logic [3:0]        wb_rd;
  logic              wb_rf_en, wb_valid;
  logic [31:0]       wb_pw;
  logic              flush;
  logic              stall;
  logic              ex_valid, ex_rf_en, ex_load;
  logic [31:0]       ex_a, ex_b, ex_d;
  logic [3:0]        ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [15:0]       stall_cnt;

  modport master (
    output id_valid, id_sa, id_sb, id_sd, id_use_a, id_use_b, id_use_d,
           id_rd, id_rf_en, id_load, id_ctrl, pa, pb, pd, ex_fwd_result,
           mem_rd, mem_rf_en, mem_valid, mem_result,
           wb_rd, wb_rf_en, wb_valid, wb_pw, flush,
    input  stall, ex_valid, ex_rf_en, ex_load, ex_a, ex_b, ex_d, ex_rd,
           ex_ctrl, stall_cnt
  );

  modport slave (
    input  id_valid, id_sa, id_sb, id_sd, id_use_a, id_use_b, id_use_d,
           id_rd, id_rf_en, id_load, id_ctrl, pa, pb, pd, ex_fwd_result,
           mem_rd, mem_rf_en, mem_valid, mem_result,
           wb_rd, wb_rf_en, wb_valid, wb_pw, flush,
    output stall, ex_valid, ex_rf_en, ex_load, ex_a, ex_b, ex_d, ex_rd,
           ex_ctrl, stall_cnt
  );
endinterface

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// operand_forward_mux: per-operand hazard detection and bypass selection.
// Build macro FWD_EN: when defined, the operand is taken from the youngest
// matching writer; otherwise it always comes from the register file port.
module operand_forward_mux
  import id_ex_operand_stage_pkg::*;
(
  input  logic        id_valid_i,
  input  logic        use_i,
  input  logic [3:0]  src_i,
  input  logic [31:0] rf_data_i,
  input  logic        ex_valid_i,
  input  logic        ex_rf_en_i,
  input  logic [3:0]  ex_rd_i,
  input  logic        mem_valid_i,
  input  logic        mem_rf_en_i,
  input  logic [3:0]  mem_rd_i,
  input  logic        wb_valid_i,
  input  logic        wb_rf_en_i,
  input  logic [3:0]  wb_rd_i,
`ifdef FWD_EN
  input  logic [31:0] ex_result_i,
  input  logic [31:0] mem_result_i,
  input  logic [31:0] wb_pw_i,
`endif
  output logic [31:0] operand_o,
  output logic        ex_match_o,
  output logic        mem_match_o,
  output logic        wb_match_o
);
  logic consumed;

  // The PC register always reads straight from the register file
  assign consumed    = id_valid_i && use_i && (src_i != REG_PC);
  assign ex_match_o  = consumed && ex_valid_i  && ex_rf_en_i  && (ex_rd_i  == src_i);
  assign mem_match_o = consumed && mem_valid_i && mem_rf_en_i && (mem_rd_i == src_i);
  assign wb_match_o  = consumed && wb_valid_i  && wb_rf_en_i  && (wb_rd_i  == src_i);

`ifdef FWD_EN
  fwd_sel_e sel;

  // Pick the youngest writer that targets this source register
  always_comb begin
    sel = FWD_RF;
    if (ex_match_o)       sel = FWD_EX;
    else if (mem_match_o) sel = FWD_MEM;
    else if (wb_match_o)  sel = FWD_WB;
  end

  // Operand bypass mux
  always_comb begin
    case (sel)
      FWD_EX:  operand_o = ex_result_i;
      FWD_MEM: operand_o = mem_result_i;
      FWD_WB:  operand_o = wb_pw_i;
      default: operand_o = rf_data_i;
    endcase
  end
`else
  assign operand_o = rf_data_i;
`endif

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: resolves A/B/D operands for the instruction in ID,
// raises STALL on unresolvable hazards and registers operands into EX.
// Build macro FWD_EN: when defined, forwarding is enabled and only load-use
// stalls; otherwise every in-flight writer match stalls.
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  id_ex_operand_stage_if.slave pipe_io
);
  logic [2:0][3:0]    src;
  logic [2:0]         use_op;
  logic [2:0][31:0]   rf_data;
  logic [2:0][31:0]   operand;
  logic [2:0]         ex_match, mem_match, wb_match;
  logic               hazard, stall, load_ex;

  logic               ex_valid_q, ex_valid_d;
  logic               ex_rf_en_q, ex_rf_en_d;
  logic               ex_load_q, ex_load_d;
  logic [31:0]        ex_a_q, ex_a_d, ex_b_q, ex_b_d, ex_d_q, ex_d_d;
  logic [3:0]         ex_rd_q, ex_rd_d;
  logic [CTRL_W-1:0]  ex_ctrl_q, ex_ctrl_d;
  logic [15:0]        stall_cnt_q;

  // Index 0 = A, 1 = B, 2 = D
  assign src     = {pipe_io.id_sd, pipe_io.id_sb, pipe_io.id_sa};
  assign use_op  = {pipe_io.id_use_d, pipe_io.id_use_b, pipe_io.id_use_a};
  assign rf_data = {pipe_io.pd, pipe_io.pb, pipe_io.pa};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_opnd
      operand_forward_mux u_mux (
        .id_valid_i   (pipe_io.id_valid),
        .use_i        (use_op[gi]),
        .src_i        (src[gi]),
        .rf_data_i    (rf_data[gi]),
        .ex_valid_i   (ex_valid_q),
        .ex_rf_en_i   (ex_rf_en_q),
        .ex_rd_i      (ex_rd_q),
        .mem_valid_i  (pipe_io.mem_valid),
        .mem_rf_en_i  (pipe_io.mem_rf_en),
        .mem_rd_i     (pipe_io.mem_rd),
        .wb_valid_i   (pipe_io.wb_valid),
        .wb_rf_en_i   (pipe_io.wb_rf_en),
        .wb_rd_i      (pipe_io.wb_rd),
`ifdef FWD_EN
        .ex_result_i  (pipe_io.ex_fwd_result),
        .mem_result_i (pipe_io.mem_result),
        .wb_pw_i      (pipe_io.wb_pw),
`endif
        .operand_o    (operand[gi]),
        .ex_match_o   (ex_match[gi]),
        .mem_match_o  (mem_match[gi]),
        .wb_match_o   (wb_match[gi])
      );
    end
  endgenerate

`ifdef FWD_EN
  // Only a load in EX cannot be bypassed: its data is not ready yet
  assign hazard = ex_load_q && (|ex_match);
`else
  // Without bypass, wait until the writer has retired through WB
  assign hazard = (|ex_match) || (|mem_match) || (|wb_match);
`endif

  // A squashed instruction never needs to wait
  assign stall   = hazard && !pipe_io.flush;
  assign load_ex = pipe_io.id_valid && !pipe_io.flush && !stall;

  // Next EX contents: a bubble clears the control bits but keeps the data
  always_comb begin
    ex_valid_d = load_ex;
    ex_rf_en_d = load_ex && pipe_io.id_rf_en;
    ex_load_d  = load_ex && pipe_io.id_load;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_d_d     = ex_d_q;
    ex_rd_d    = ex_rd_q;
    ex_ctrl_d  = ex_ctrl_q;
    if (load_ex) begin
      ex_a_d    = operand[0];
      ex_b_d    = operand[1];
      ex_d_d    = operand[2];
      ex_rd_d   = pipe_io.id_rd;
      ex_ctrl_d = pipe_io.id_ctrl;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_rf_en_q <= 1'b0;
      ex_load_q  <= 1'b0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_d_q     <= '0;
      ex_rd_q    <= '0;
      ex_ctrl_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_rf_en_q <= ex_rf_en_d;
      ex_load_q  <= ex_load_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_d_q     <= ex_d_d;
      ex_rd_q    <= ex_rd_d;
      ex_ctrl_q  <= ex_ctrl_d;
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign pipe_io.stall     = stall;
  assign pipe_io.ex_valid  = ex_valid_q;
  assign pipe_io.ex_rf_en  = ex_rf_en_q;
  assign pipe_io.ex_load   = ex_load_q;
  assign pipe_io.ex_a      = ex_a_q;
  assign pipe_io.ex_b      = ex_b_q;
  assign pipe_io.ex_d      = ex_d_q;
  assign pipe_io.ex_rd     = ex_rd_q;
  assign pipe_io.ex_ctrl   = ex_ctrl_q;
  assign pipe_io.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage; expectations follow whichever
// FWD_EN build is compiled.
module tb_id_ex_operand_stage;
  import id_ex_operand_stage_pkg::*;

  typedef struct packed {
    logic        vld;
    logic [3:0]  sa, sb, sd;
    logic        ua, ub, ud;
    logic [3:0]  rd;
    logic        rf_en, load;
    logic [15:0] ctrl;
    logic [31:0] pa, pb, pd, exr;
    logic [3:0]  mrd;
    logic        mren, mvld;
    logic [31:0] mres;
    logic [3:0]  wrd;
    logic        wren, wvld;
    logic [31:0] wpw;
    logic        flush;
  } stim_t;

  typedef struct {
    string       name;
    logic        stall, valid, rf_en, load, chk;
    logic [31:0] a, b, d;
    logic [3:0]  rd;
    logic [15:0] ctrl, cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_total = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  id_ex_operand_stage_if bus_if ();

  id_ex_operand_stage dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pipe_io (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic drive(input stim_t s);
    bus_if.id_valid = s.vld;   bus_if.id_sa = s.sa;   bus_if.id_sb = s.sb;
    bus_if.id_sd = s.sd;       bus_if.id_use_a = s.ua; bus_if.id_use_b = s.ub;
    bus_if.id_use_d = s.ud;    bus_if.id_rd = s.rd;   bus_if.id_rf_en = s.rf_en;
    bus_if.id_load = s.load;   bus_if.id_ctrl = s.ctrl;
    bus_if.pa = s.pa;          bus_if.pb = s.pb;      bus_if.pd = s.pd;
    bus_if.ex_fwd_result = s.exr;
    bus_if.mem_rd = s.mrd;     bus_if.mem_rf_en = s.mren; bus_if.mem_valid = s.mvld;
    bus_if.mem_result = s.mres;
    bus_if.wb_rd = s.wrd;      bus_if.wb_rf_en = s.wren;  bus_if.wb_valid = s.wvld;
    bus_if.wb_pw = s.wpw;      bus_if.flush = s.flush;
  endtask

  function automatic exp_t mk(input string name, input logic stall, input logic valid,
                              input logic rf_en, input logic load, input logic [31:0] a,
                              input logic [31:0] b, input logic [3:0] rd,
                              input logic [15:0] ctrl, input logic [15:0] cnt);
    exp_t e;
    e.name = name; e.stall = stall; e.valid = valid; e.rf_en = rf_en; e.load = load;
    e.chk = 1'b1; e.a = a; e.b = b; e.d = 32'h0; e.rd = rd; e.ctrl = ctrl; e.cnt = cnt;
    return e;
  endfunction

  // Apply one cycle of ID-stage stimulus and queue its expected response
  task automatic step(input stim_t s, input exp_t e);
    @(negedge clk);
    #1;
    drive(s);
    exp_q.push_back(e);
  endtask

  // Assert reset while a stall is pending and check outputs clear at once
  task automatic reset_mid_stall(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    check({name, " rst stall"}, 32'(bus_if.stall), 32'h0);
    check({name, " rst valid"}, 32'(bus_if.ex_valid), 32'h0);
    check({name, " rst load"}, 32'(bus_if.ex_load), 32'h0);
    check({name, " rst rd"}, 32'(bus_if.ex_rd), 32'h0);
    check({name, " rst ctrl"}, 32'(bus_if.ex_ctrl), 32'h0);
    check({name, " rst cnt"}, 32'(bus_if.stall_cnt), 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: stall sampled mid-cycle, EX registers just after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, " stall"}, 32'(bus_if.stall), 32'(e.stall));
        @(posedge clk);
        #1;
        check({e.name, " ex_valid"}, 32'(bus_if.ex_valid), 32'(e.valid));
        check({e.name, " ex_rf_en"}, 32'(bus_if.ex_rf_en), 32'(e.rf_en));
        check({e.name, " ex_load"}, 32'(bus_if.ex_load), 32'(e.load));
        check({e.name, " stall_cnt"}, 32'(bus_if.stall_cnt), 32'(e.cnt));
        if (e.chk) begin
          check({e.name, " ex_a"}, bus_if.ex_a, e.a);
          check({e.name, " ex_b"}, bus_if.ex_b, e.b);
          check({e.name, " ex_d"}, bus_if.ex_d, e.d);
          check({e.name, " ex_rd"}, 32'(bus_if.ex_rd), 32'(e.rd));
          check({e.name, " ex_ctrl"}, 32'(bus_if.ex_ctrl), 32'(e.ctrl));
        end
        $display("txn %s stall=%0b valid=%0b a=%0h b=%0h cnt=%0d", e.name,
                 bus_if.stall, bus_if.ex_valid, bus_if.ex_a, bus_if.ex_b, bus_if.stall_cnt);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    int    wait_cycles;
    s = '0;
    drive(s);
    repeat (2) @(negedge clk);
    #1;
    check("reset ex_valid", 32'(bus_if.ex_valid), 32'h0);
    check("reset ex_a", bus_if.ex_a, 32'h0);
    check("reset stall_cnt", 32'(bus_if.stall_cnt), 32'h0);
    check("reset stall", 32'(bus_if.stall), 32'h0);
    rst_n = 1'b1;

    // Plain pass-through
    s = '0; s.vld = 1; s.sa = 1; s.sb = 2; s.ua = 1; s.ub = 1; s.pa = 7; s.pb = 9; s.ctrl = 16'h1;
    step(s, mk("pass", 0, 1, 0, 0, 32'h7, 32'h9, 4'd0, 16'h1, 16'd0));
    // R15 never forwarded even with a WB writer on R15
    s = '0; s.vld = 1; s.sa = 15; s.ua = 1; s.pa = 32'h40; s.ctrl = 16'h2;
    s.wrd = 15; s.wren = 1; s.wvld = 1; s.wpw = 32'h99;
    step(s, mk("r15", 0, 1, 0, 0, 32'h40, 32'h0, 4'd0, 16'h2, 16'd0));

`ifdef FWD_EN
    s = '0; s.vld = 1; s.rd = 3; s.rf_en = 1; s.ctrl = 16'h3;
    step(s, mk("wr_r3", 0, 1, 1, 0, 32'h0, 32'h0, 4'd3, 16'h3, 16'd0));
    s = '0; s.vld = 1; s.sa = 3; s.ua = 1; s.ctrl = 16'h4; s.exr = 32'h11;
    s.mrd = 3; s.mren = 1; s.mvld = 1; s.mres = 32'h22;
    s.wrd = 3; s.wren = 1; s.wvld = 1; s.wpw = 32'h33;
    step(s, mk("fwd_ex", 0, 1, 0, 0, 32'h11, 32'h0, 4'd0, 16'h4, 16'd0));
    s.ctrl = 16'h5;
    step(s, mk("fwd_mem", 0, 1, 0, 0, 32'h22, 32'h0, 4'd0, 16'h5, 16'd0));
    s.ctrl = 16'h6; s.mren = 0;
    step(s, mk("fwd_wb", 0, 1, 0, 0, 32'h33, 32'h0, 4'd0, 16'h6, 16'd0));
    // Load-use: one bubble, then the load data arrives from MEM
    s = '0; s.vld = 1; s.rd = 4; s.rf_en = 1; s.load = 1; s.ctrl = 16'h7;
    step(s, mk("load_r4", 0, 1, 1, 1, 32'h0, 32'h0, 4'd4, 16'h7, 16'd0));
    s = '0; s.vld = 1; s.sb = 4; s.ub = 1; s.pb = 32'h77; s.exr = 32'hDEAD; s.ctrl = 16'h8;
    step(s, mk("lu_stall", 1, 0, 0, 0, 32'h0, 32'h0, 4'd4, 16'h7, 16'd1));
    s.mrd = 4; s.mren = 1; s.mvld = 1; s.mres = 32'h55;
    step(s, mk("lu_mem", 0, 1, 0, 0, 32'h0, 32'h55, 4'd0, 16'h8, 16'd1));
    // Flush overrides a load-use hazard
    s = '0; s.vld = 1; s.rd = 6; s.rf_en = 1; s.load = 1; s.ctrl = 16'h9;
    step(s, mk("load_r6", 0, 1, 1, 1, 32'h0, 32'h0, 4'd6, 16'h9, 16'd1));
    s = '0; s.vld = 1; s.sa = 6; s.ua = 1; s.pa = 32'h66; s.flush = 1; s.ctrl = 16'hA;
    step(s, mk("flush", 0, 0, 0, 0, 32'h0, 32'h0, 4'd6, 16'h9, 16'd1));
    // Reset asserted during a load-use stall
    s = '0; s.vld = 1; s.rd = 6; s.rf_en = 1; s.load = 1; s.ctrl = 16'hB;
    step(s, mk("load_r6b", 0, 1, 1, 1, 32'h0, 32'h0, 4'd6, 16'hB, 16'd1));
    s = '0; s.vld = 1; s.sa = 6; s.ua = 1; s.pa = 32'h66; s.ctrl = 16'hC;
    step(s, mk("lu_rst", 1, 0, 0, 0, 32'h0, 32'h0, 4'd0, 16'h0, 16'd0));
    reset_mid_stall("lu_rst");
    step(s, mk("after_rst", 0, 1, 0, 0, 32'h66, 32'h0, 4'd0, 16'hC, 16'd0));
`else
    // MEM writer: stall while in MEM, then in WB, then read the register file
    s = '0; s.vld = 1; s.sa = 5; s.ua = 1; s.pa = 32'hAB; s.ctrl = 16'h3;
    s.mrd = 5; s.mren = 1; s.mvld = 1; s.mres = 32'h22;
    step(s, mk("mem_stall", 1, 0, 0, 0, 32'h40, 32'h0, 4'd0, 16'h2, 16'd1));
    s.mren = 0; s.mvld = 0; s.wrd = 5; s.wren = 1; s.wvld = 1; s.wpw = 32'h33;
    step(s, mk("wb_stall", 1, 0, 0, 0, 32'h40, 32'h0, 4'd0, 16'h2, 16'd2));
    s.wren = 0; s.wvld = 0;
    step(s, mk("rf_read", 0, 1, 0, 0, 32'hAB, 32'h0, 4'd0, 16'h3, 16'd2));
    // EX writer: three stall cycles
    s = '0; s.vld = 1; s.rd = 7; s.rf_en = 1; s.ctrl = 16'h4;
    step(s, mk("wr_r7", 0, 1, 1, 0, 32'h0, 32'h0, 4'd7, 16'h4, 16'd2));
    s = '0; s.vld = 1; s.sa = 7; s.ua = 1; s.pa = 32'h70; s.ctrl = 16'h5;
    step(s, mk("ex_stall", 1, 0, 0, 0, 32'h0, 32'h0, 4'd7, 16'h4, 16'd3));
    s.mrd = 7; s.mren = 1; s.mvld = 1;
    step(s, mk("ex_mem_stall", 1, 0, 0, 0, 32'h0, 32'h0, 4'd7, 16'h4, 16'd4));
    s.mren = 0; s.mvld = 0; s.wrd = 7; s.wren = 1; s.wvld = 1;
    step(s, mk("ex_wb_stall", 1, 0, 0, 0, 32'h0, 32'h0, 4'd7, 16'h4, 16'd5));
    s.wren = 0; s.wvld = 0;
    step(s, mk("ex_done", 0, 1, 0, 0, 32'h70, 32'h0, 4'd0, 16'h5, 16'd5));
    // Flush overrides the hazard
    s = '0; s.vld = 1; s.sa = 7; s.ua = 1; s.mrd = 7; s.mren = 1; s.mvld = 1;
    s.flush = 1; s.ctrl = 16'h6;
    step(s, mk("flush", 0, 0, 0, 0, 32'h70, 32'h0, 4'd0, 16'h5, 16'd5));
    // Reset asserted during an EX-writer stall
    s = '0; s.vld = 1; s.rd = 9; s.rf_en = 1; s.ctrl = 16'h7;
    step(s, mk("wr_r9", 0, 1, 1, 0, 32'h0, 32'h0, 4'd9, 16'h7, 16'd5));
    s = '0; s.vld = 1; s.sa = 9; s.ua = 1; s.pa = 32'h90; s.ctrl = 16'h8;
    step(s, mk("ex_rst", 1, 0, 0, 0, 32'h0, 32'h0, 4'd0, 16'h0, 16'd0));
    reset_mid_stall("ex_rst");
    step(s, mk("after_rst", 0, 1, 0, 0, 32'h90, 32'h0, 4'd0, 16'h8, 16'd0));
`endif

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
